// File: rtl/alu_stack_fpga.sv
// RPN calculator: debounced pushbuttons drive a 32-bit operand stack and ALU,
// with the top entries shown on eight seven-segment digits and status on LEDs.
module alu_stack_fpga #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic        CLOCK_50,
    input  logic        RST,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [17:0] LEDR
);

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [6:0]  SEG_DASH = 7'b0111111;

    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_OR   = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOR  = 4'h5,
        OP_SLL  = 4'h6,
        OP_SRL  = 4'h7,
        OP_SRA  = 4'h8,
        OP_SLT  = 4'h9,
        OP_PASA = 4'hA,
        OP_PASB = 4'hB
    } aluop_t;

    logic [3:0]     key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [1:0]     fill_q, fill_d;
    logic [3:0]     db_q, db_d, db_prev_q, db_prev_d, armed_q, armed_d;
    logic [DBW-1:0] db_cnt_q [4];
    logic [DBW-1:0] db_cnt_d [4];
    logic [3:0]     pulse_c;

    logic [DW-1:0]  mem_q [DEPTH];
    logic [DW-1:0]  mem_d [DEPTH];
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
    logic           err_unf_q, err_unf_d, err_ovf_q, err_ovf_d;

    logic [IW-1:0]  tos_idx, nos_idx, push_idx;
    logic           full, empty;
    logic [DW-1:0]  alu_a, alu_b, alu_y, sum, diff;
    logic           alu_ov;
    aluop_t         alu_op;

    logic [DW-1:0]  disp_word;
    logic           disp_valid;

    // Synchronizers, debouncers and press-edge detection
    always_comb begin
        key_s1_d  = KEY;
        key_s2_d  = key_s1_q;
        fill_d    = {fill_q[0], 1'b1};
        db_prev_d = db_q;
        db_d      = db_q;
        // A key held through reset must be seen released before it can fire
        armed_d   = armed_q | (fill_q[1] ? key_s2_q : 4'b0000);
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (key_s2_q[i] != db_q[i]) begin
                if (32'(db_cnt_q[i]) + 32'd1 == 32'(DEBOUNCE_CYC)) begin
                    db_d[i] = key_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        pulse_c = armed_q & db_prev_q & ~db_q & {4{~RST}};
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            key_s1_q  <= 4'hF;
            key_s2_q  <= 4'hF;
            fill_q    <= 2'b00;
            db_q      <= 4'hF;
            db_prev_q <= 4'hF;
            armed_q   <= 4'h0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            key_s1_q  <= key_s1_d;
            key_s2_q  <= key_s2_d;
            fill_q    <= fill_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            armed_q   <= armed_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign tos_idx  = IW'(cnt_q - 1'b1);
    assign nos_idx  = IW'(cnt_q - 2'd2);
    assign push_idx = IW'(cnt_q);
    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign alu_a    = mem_q[nos_idx];
    assign alu_b    = mem_q[tos_idx];
    assign alu_op   = aluop_t'(SW[3:0]);
    assign sum      = alu_a + alu_b;
    assign diff     = alu_a - alu_b;

    // ALU: signed overflow only meaningful for add/subtract
    always_comb begin
        alu_y  = '0;
        alu_ov = 1'b0;
        case (alu_op)
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_ADD: begin
                alu_y  = sum;
                alu_ov = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            OP_SUB: begin
                alu_y  = diff;
                alu_ov = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            OP_XOR:  alu_y = alu_a ^ alu_b;
            OP_NOR:  alu_y = ~(alu_a | alu_b);
            OP_SLL:  alu_y = alu_a << alu_b[4:0];
            OP_SRL:  alu_y = alu_a >> alu_b[4:0];
            OP_SRA:  alu_y = DW'($signed(alu_a) >>> alu_b[4:0]);
            OP_SLT:  alu_y = DW'($signed(alu_a) < $signed(alu_b));
            OP_PASA: alu_y = alu_a;
            OP_PASB: alu_y = alu_b;
            default: alu_y = '0;
        endcase
    end

    // Stack command execution; priority clear > drop > execute > push
    always_comb begin
        mem_d     = mem_q;
        cnt_d     = cnt_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        err_unf_d = err_unf_q;
        err_ovf_d = err_ovf_q;
        if (pulse_c[3]) begin
            cnt_d     = '0;
            zero_d    = 1'b0;
            neg_d     = 1'b0;
            ovf_d     = 1'b0;
            err_unf_d = 1'b0;
            err_ovf_d = 1'b0;
        end else if (pulse_c[2]) begin
            if (empty) err_unf_d = 1'b1;
            else       cnt_d     = cnt_q - 1'b1;
        end else if (pulse_c[1]) begin
            if (cnt_q < CW'(2)) begin
                err_unf_d = 1'b1;
            end else begin
                mem_d[nos_idx] = alu_y;
                cnt_d          = cnt_q - 1'b1;
                zero_d         = (alu_y == '0);
                neg_d          = alu_y[31];
                ovf_d          = alu_ov;
            end
        end else if (pulse_c[0]) begin
            if (full) begin
                err_ovf_d = 1'b1;
            end else begin
                mem_d[push_idx] = {{16{SW[16]}}, SW[15:0]};
                cnt_d           = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            cnt_q     <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            err_unf_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            err_unf_q <= err_unf_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by cnt_q
    always_ff @(posedge CLOCK_50) begin
        mem_q <= mem_d;
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b0100111;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign disp_valid = SW[17] ? (cnt_q >= CW'(2)) : !empty;
    assign disp_word  = SW[17] ? alu_a : alu_b;

    assign HEX0 = disp_valid ? seg7(disp_word[3:0])   : SEG_DASH;
    assign HEX1 = disp_valid ? seg7(disp_word[7:4])   : SEG_DASH;
    assign HEX2 = disp_valid ? seg7(disp_word[11:8])  : SEG_DASH;
    assign HEX3 = disp_valid ? seg7(disp_word[15:12]) : SEG_DASH;
    assign HEX4 = disp_valid ? seg7(disp_word[19:16]) : SEG_DASH;
    assign HEX5 = disp_valid ? seg7(disp_word[23:20]) : SEG_DASH;
    assign HEX6 = disp_valid ? seg7(disp_word[27:24]) : SEG_DASH;
    assign HEX7 = disp_valid ? seg7(disp_word[31:28]) : SEG_DASH;

    assign LEDR = {SW[17], full, empty, 5'b00000, 5'(cnt_q),
                   err_ovf_q, err_unf_q, ovf_q, neg_q, zero_q};

endmodule

// File: tb/tb_alu_stack_fpga.sv
// Directed bench for alu_stack_fpga with DEPTH=4, DEBOUNCE_CYC=2.
module tb_alu_stack_fpga;

    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic [17:0] sw;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [17:0] ledr;
    int          checks = 0;
    int          errors = 0;

    alu_stack_fpga #(.DEPTH(4), .DEBOUNCE_CYC(2)) dut (
        .CLOCK_50(clk), .RST(rst), .KEY(key), .SW(sw),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
        .HEX4(hex4), .HEX5(hex5), .HEX6(hex6), .HEX7(hex7),
        .LEDR(ledr)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask);
        key = key & ~mask;
        cyc(6);
        key = key | mask;
        cyc(6);
    endtask

    task automatic push(input logic [16:0] v);
        sw[16:0] = v;
        press(4'b0001);
    endtask

    task automatic exe(input logic [3:0] op);
        sw[3:0] = op;
        press(4'b0010);
    endtask

    initial begin
        rst = 1'b1;
        key = 4'hF;
        sw  = '0;
        cyc(3);
        check("rst_ledr", 32'(ledr), 32'h08000);
        check("rst_hex0", 32'(hex0), 32'(DASH));
        check("rst_hex7", 32'(hex7), 32'(DASH));
        rst = 1'b0;
        cyc(4);

        // Key-to-effect latency: 2 sync + 2 debounce + 1
        sw[16:0] = 17'h00005;
        key[0] = 1'b0;
        cyc(4);
        check("lat_before", 32'(ledr), 32'h08000);
        cyc(1);
        check("lat_after", 32'(ledr), 32'h00020);
        key[0] = 1'b1;
        cyc(6);

        push(17'h00003);
        exe(4'h2);
        check("add_ledr", 32'(ledr), 32'h00020);
        check("add_hex0", 32'(hex0), 32'(S8));
        check("add_hex1", 32'(hex1), 32'(S0));
        check("add_hex7", 32'(hex7), 32'(S0));
        press(4'b1000);
        check("clr1_ledr", 32'(ledr), 32'h08000);

        push(17'h00003);
        push(17'h00005);
        exe(4'h3);
        check("sub_ledr", 32'(ledr), 32'h00022);
        check("sub_hex0", 32'(hex0), 32'(SE));
        check("sub_hex7", 32'(hex7), 32'(SF));
        push(17'h10002);
        check("sext_ledr", 32'(ledr), 32'h00042);
        check("sext_hex0", 32'(hex0), 32'(S2));
        check("sext_hex3", 32'(hex3), 32'(S0));
        check("sext_hex4", 32'(hex4), 32'(SF));
        sw[17] = 1'b1;
        cyc(1);
        check("nos_ledr", 32'(ledr), 32'h20042);
        check("nos_hex0", 32'(hex0), 32'(SE));
        check("nos_hex1", 32'(hex1), 32'(SF));
        sw[17] = 1'b0;
        press(4'b1000);

        push(17'h00005);
        push(17'h00005);
        exe(4'h3);
        check("zero_ledr", 32'(ledr), 32'h00021);
        check("zero_hex7", 32'(hex7), 32'(S0));
        press(4'b1000);

        push(17'h00001);
        push(17'h00002);
        push(17'h00003);
        push(17'h00004);
        check("full_ledr", 32'(ledr), 32'h10080);
        push(17'h00005);
        check("ovf_ledr", 32'(ledr), 32'h10090);
        check("ovf_hex0", 32'(hex0), 32'(S4));
        press(4'b1000);

        push(17'h00007);
        exe(4'h2);
        check("unf_ledr", 32'(ledr), 32'h00028);
        check("unf_hex0", 32'(hex0), 32'(S7));
        press(4'b0100);
        check("drop_ledr", 32'(ledr), 32'h08008);
        check("drop_hex0", 32'(hex0), 32'(DASH));
        press(4'b1000);
        check("clr2_ledr", 32'(ledr), 32'h08000);

        // One-cycle glitch must be rejected
        key[0] = 1'b0;
        cyc(1);
        key[0] = 1'b1;
        cyc(10);
        check("glitch_ledr", 32'(ledr), 32'h08000);

        push(17'h00001);
        push(17'h00002);
        press(4'b0101);
        check("prio_ledr", 32'(ledr), 32'h00020);
        check("prio_hex0", 32'(hex0), 32'(S1));

        push(17'h00002);
        sw[16:0] = 17'h00003;
        key[0] = 1'b0;
        cyc(6);
        check("held_ledr", 32'(ledr), 32'h00060);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst2_ledr", 32'(ledr), 32'h08000);
        cyc(12);
        check("rst2_held_ledr", 32'(ledr), 32'h08000);
        check("rst2_held_hex0", 32'(hex0), 32'(DASH));
        key[0] = 1'b1;
        cyc(8);
        push(17'h0000A);
        check("repress_ledr", 32'(ledr), 32'h00020);
        check("repress_hex0", 32'(hex0), 32'(SA));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_stack_fpga.md
ALU_STACK_FPGA -- requirements
Module: alu_stack_fpga

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of 32-bit operand stack entries, legal range 2..16.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 500000: consecutive stable cycles needed to accept a key level, minimum 1.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port KEY, input, 4 bits: active-low pushbuttons; KEY[0] push, KEY[1] execute, KEY[2] drop, KEY[3] clear.
REQ-006 SHALL have port SW, input, 18 bits: SW[15:0] literal, SW[16] literal sign-fill, SW[3:0] also the ALU opcode (aluop_t), SW[17] display select.
REQ-007 SHALL have ports HEX7..HEX0, output, 7 bits each: active-low seven-segment digits, HEX0 least significant nibble.
REQ-008 SHALL have port LEDR, output, 18 bits: status bits as defined in REQ-021.

Function
REQ-009 SHALL pass each KEY bit through a 2-flop synchronizer, then through a per-key debouncer that updates its accepted level only after the synchronized level has differed from it for DEBOUNCE_CYC consecutive cycles.
REQ-010 SHALL generate a one-cycle command pulse on the cycle the accepted level of a key goes pressed (0); releases generate nothing.
REQ-011 SHALL resolve simultaneous pulses by priority, serving only the highest: clear > drop > execute > push.
REQ-012 SHALL keep a LIFO of DEPTH 32-bit entries with count register cnt (0..DEPTH); TOS = entry cnt-1, NOS = entry cnt-2.
REQ-013 Push SHALL write {16{SW[16]},SW[15:0]} as the new TOS and increment cnt on the clock edge after the pulse; if cnt==DEPTH, it SHALL leave the stack unchanged and set err_ovf.
REQ-014 Execute with cnt>=2 SHALL drive the existing alu (via alu_if) with port_A=NOS, port_B=TOS, ALUOP=SW[3:0]; it SHALL pop both, push output_port, decrement cnt by 1, and latch overflow/negative/zero into flag registers on the same edge.
REQ-015 Execute with cnt<2 SHALL leave stack and flags unchanged and set err_unf.
REQ-016 Drop with cnt>0 SHALL decrement cnt; with cnt==0 it SHALL set err_unf; entry contents need not be cleared.
REQ-017 Clear SHALL set cnt=0 and clear err_ovf, err_unf and all three flags.
REQ-018 err_ovf and err_unf SHALL be sticky until clear or RST.
REQ-019 Displayed word SHALL be TOS when SW[17]=0 and NOS when SW[17]=1; if the selected entry does not exist (cnt==0, or cnt<2 with SW[17]=1), all eight digits SHALL show a dash (7'b0111111).
REQ-020 Digit encoding SHALL be active-low hex: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110.
REQ-021 LEDR SHALL map as follows: [0] zero, [1] negative, [2] overflow, [3] err_unf, [4] err_ovf, [9:5] cnt (zero-extended), [15] empty (cnt==0), [16] full (cnt==DEPTH), [17] SW[17] echo; all other bits 0.
REQ-022 HEX and LEDR SHALL be combinational from registered state, so a command's effect is visible one cycle after its pulse.
REQ-023 Total latency from a KEY edge to the visible effect SHALL be 2 synchronizer cycles + DEBOUNCE_CYC + 1 cycle.

Reset
REQ-024 RST high at a clock edge SHALL set cnt=0, all flags and errors to 0, synchronizers and debouncers to released (1), and suppress any pulse in the same cycle.
REQ-025 After reset, HEX7..HEX0 SHALL show dashes and LEDR SHALL equal 18'h08000.
REQ-026 RST asserted while a key is held SHALL NOT produce a pulse until that key is released and pressed again.

Verification (DEBOUNCE_CYC=2, DEPTH=4)
REQ-027 Push 0x0005, push 0x0003, execute with SW[3:0]=ADD(4'h2) -> TOS=0x00000008, cnt=1, zero=0, HEX0 shows 8, HEX7..HEX1 show 0.
REQ-028 Push 0x0003, push 0x0005, execute SUB(4'h3) -> TOS=0xFFFFFFFE, negative=1; push 0x0002 with SW[16]=1 -> TOS=0xFFFF0002.
REQ-029 Five pushes -> cnt=4, LEDR[16]=1, LEDR[4]=1 after the fifth; TOS holds the fourth value.
REQ-030 With cnt=1, execute -> err_unf=1 and stack unchanged; drop -> cnt=0, dashes shown; clear -> LEDR=18'h08000.
REQ-031 KEY[0] glitch low for 1 cycle -> no push; KEY[0] and KEY[2] pressed together with cnt=2 -> only drop occurs (cnt=1).
REQ-032 RST pulse mid-sequence with cnt=3 -> next cycle cnt=0, LEDR=18'h08000, no command pulse while keys remain held.
